uart_rx_8n1: RTL and testbench

- Serial receiver for the Fomu user pads.
- Deserialises 8N1 asynchronous frames at the same bit period as the board's UART transmitter, and checks each frame.
- Delivers each byte over a valid/ready interface.
- Sits downstream of the transmitter in loopback test builds (user_2 wired to user_1), and upstream of host-command logic.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 45 ++++
 rtl/uart_rx_8n1.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_8n1.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the Fomu UART transmitter and receiver.
//   CLKS_PER_BIT_DEFAULT : clk cycles per bit at 48 MHz / 9600 baud
//   rx_state_e           : receive FSM states
//   CH_0 / CH_1 / CH_LF  : ASCII characters used by the loopback line format
package uart_pkg;

   localparam int unsigned CLKS_PER_BIT_DEFAULT = 5000;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_e;

   localparam logic [7:0] CH_0  = 8'h30;
   localparam logic [7:0] CH_1  = 8'h31;
   localparam logic [7:0] CH_LF = 8'h0A;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for the asynchronous serial line plus a
// short history of the synchronised level for 2-of-3 majority voting.
//   clk    in  system clock
//   rst    in  synchronous active-high reset (all flops reset to 1 = idle line)
//   rx_in  in  asynchronous serial line
//   rxs    out synchronised line level
//   maj    out majority of rxs in this cycle and the two previous cycles
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx_in,
   output logic rxs,
   output logic maj
);

   logic       meta_q, meta_d;
   logic       sync_q, sync_d;
   logic [1:0] hist_q, hist_d;

   always_comb begin
      meta_d = rx_in;
      sync_d = meta_q;
      hist_d = {hist_q[0], sync_q};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         hist_q <= '1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   // The vote includes the current level so a decision taken in a cycle
   // covers that cycle and the two before it.
   always_comb begin
      rxs = sync_q;
      maj = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync_q) | (hist_q[0] & sync_q);
   end

endmodule

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 serial receiver with mid-bit 2-of-3 sampling, frame/break
// detection and a valid/ready byte output.
//   clk        in  48 MHz system clock
//   rst        in  synchronous active-high reset
//   rx_in      in  asynchronous serial line, idle high
//   rx_data    out received byte (first bit on the wire in bit 0)
//   rx_valid   out rx_data holds an unconsumed byte
//   rx_ready   in  consumer takes rx_data when rx_valid && rx_ready
//   frame_err  out one-cycle pulse: stop bit low, data nonzero
//   break_det  out one-cycle pulse: stop bit low, data all zero
//   overrun    out one-cycle pulse: good byte dropped, previous one unconsumed
//   rx_busy    out receiver is inside a frame
module uart_rx_8n1
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       break_det,
   output logic       overrun,
   output logic       rx_busy
);

   localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] SUB_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] SUB_MID  = CNT_W'(HALF_BIT);

   logic rxs, maj;

   uart_rx_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .rx_in (rx_in),
      .rxs   (rxs),
      .maj   (maj)
   );

   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] sub_q, sub_d;
   logic [3:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             fe_q, fe_d;
   logic             bd_q, bd_d;
   logic             ov_q, ov_d;
   logic             busy_q, busy_d;
   logic             armed_q, armed_d;
   logic [1:0]       settle_q, settle_d;
   logic             sample_pt;

   always_comb begin
      state_d  = state_q;
      sub_d    = sub_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      data_d   = data_q;
      valid_d  = valid_q;
      fe_d     = 1'b0;
      bd_d     = 1'b0;
      ov_d     = 1'b0;
      busy_d   = (state_q != IDLE);
      // The synchroniser resets to 1, so rxs only reflects the real line two
      // cycles after reset; a start is accepted only once the line has been
      // seen high after that point.
      settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
      armed_d  = armed_q | ((settle_q == 2'd2) & rxs);

      sample_pt = (sub_q == SUB_MID);

      if (valid_q && rx_ready) begin
         valid_d = 1'b0;
      end

      if (state_q == START || state_q == DATA || state_q == STOP) begin
         if (sub_q == SUB_LAST) begin
            sub_d = '0;
            bit_d = bit_q + 4'd1;
         end else begin
            sub_d = sub_q + CNT_W'(1);
         end
      end

      case (state_q)
         IDLE: begin
            if (armed_q && !rxs) begin
               state_d = START;
               sub_d   = '0;
               bit_d   = '0;
            end
         end
         START: begin
            if (sample_pt) begin
               state_d = maj ? IDLE : DATA;
            end
         end
         DATA: begin
            if (sample_pt) begin
               shift_d = {maj, shift_q[7:1]};
               if (bit_q == 4'd8) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (sample_pt) begin
               if (maj) begin
                  // A byte accepted in this same cycle frees the holding
                  // register, so the new byte replaces it without overrun.
                  if (valid_q && !rx_ready) begin
                     ov_d = 1'b1;
                  end else begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end
                  state_d = IDLE;
               end else begin
                  if (shift_q == 8'h00) begin
                     bd_d = 1'b1;
                  end else begin
                     fe_d = 1'b1;
                  end
                  state_d = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            if (rxs) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sub_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         fe_q     <= 1'b0;
         bd_q     <= 1'b0;
         ov_q     <= 1'b0;
         busy_q   <= 1'b0;
         armed_q  <= 1'b0;
         settle_q <= '0;
      end else begin
         state_q  <= state_d;
         sub_q    <= sub_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         fe_q     <= fe_d;
         bd_q     <= bd_d;
         ov_q     <= ov_d;
         busy_q   <= busy_d;
         armed_q  <= armed_d;
         settle_q <= settle_d;
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = fe_q;
   assign break_det = bd_q;
   assign overrun   = ov_q;
   assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: self-checking bench for uart_rx_8n1 with a short bit period.
// The bench acts as the serial transmitter; expected bytes are the bytes it
// sends and expected timing follows from the frame timing rules.
`timescale 1ns/1ps
module tb_uart_rx_8n1;
   import uart_pkg::*;

   localparam int CPB = 16;
   localparam int HB  = CPB / 2;
   // pin falling edge -> rx_valid high: 2 sync cycles + 9 bits + HB + 2
   localparam int LAT = 2 + 9 * CPB + HB + 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_in = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, break_det, overrun, rx_busy;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   int         rise_cyc[$];
   logic [7:0] rise_data[$];
   logic [7:0] acc_data[$];
   int fe_cnt, bd_cnt, ov_cnt, fe_cyc, bd_cyc, ov_cyc, valid_cycles;
   logic valid_prev = 1'b0;

   uart_rx_8n1 #(.CLKS_PER_BIT(CPB), .HALF_BIT(HB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_in     (rx_in),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .break_det (break_det),
      .overrun   (overrun),
      .rx_busy   (rx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // event log sampled mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && !valid_prev) begin
            rise_cyc.push_back(cyc);
            rise_data.push_back(rx_data);
         end
         if (rx_valid) valid_cycles++;
         if (rx_valid && rx_ready) acc_data.push_back(rx_data);
         if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
         if (break_det) begin bd_cnt++; bd_cyc = cyc; end
         if (overrun)   begin ov_cnt++; ov_cyc = cyc; end
      end
      valid_prev = rx_valid;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected end of stimulus");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      rise_cyc.delete();
      rise_data.delete();
      acc_data.delete();
      fe_cnt = 0; bd_cnt = 0; ov_cnt = 0; valid_cycles = 0;
      fe_cyc = -1; bd_cyc = -1; ov_cyc = -1;
   endtask

   // Drive one 8N1 frame. flip_idx inverts the line for one cycle, rdy_idx
   // pulses rx_ready for one cycle, abort_idx resets both ends mid-frame.
   task automatic send_frame(input logic [7:0] b, input logic stop_v,
                             input int flip_idx, input int rdy_idx,
                             input int abort_idx, output int start_c);
      logic [9:0] fr;
      logic       v;
      bit         aborted;
      fr = {stop_v, b, 1'b0};
      aborted = 0;
      start_c = -1;
      for (int i = 0; i < 10 * CPB; i++) begin
         step();
         if (i == 0) start_c = cyc;
         if (i == abort_idx) begin
            rx_in = 1'b1;
            rst = 1'b1;
            step();
            rst = 1'b0;
            aborted = 1;
            break;
         end
         v = fr[i / CPB];
         if (i == flip_idx) v = ~v;
         rx_in = v;
         if (rdy_idx >= 0) begin
            if (i == rdy_idx) rx_ready = 1'b1;
            else if (i == rdy_idx + 1) rx_ready = 1'b0;
         end
      end
      if (!aborted) begin
         step();
         rx_in = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_in = 1'b1; rx_ready = 1'b0;
      repeat (3) step();
      n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
      n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rx_data); end
      n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      n_checks++; if (break_det !== 1'b0) begin n_fail++; $display("FAIL reset_break_det: got %b expected 0", break_det); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
      n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
      rst = 1'b0;
      repeat (4) step();
      n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", rx_busy); end
   endtask

   task automatic test_reset_low_line();
      logic [7:0] b;
      int s;
      rst = 1'b1; rx_in = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      clear_log();
      repeat (12 * CPB) step();
      n_checks++; if (bd_cnt + fe_cnt !== 0) begin n_fail++; $display("FAIL lowline_errors: got %0d expected 0", bd_cnt + fe_cnt); end
      n_checks++; if (rise_cyc.size() !== 0) begin n_fail++; $display("FAIL lowline_valid: got %0d expected 0", rise_cyc.size()); end
      rx_in = 1'b1;
      repeat (CPB) step();
      b = 8'($urandom);
      rx_ready = 1'b1;
      send_frame(b, 1'b1, -1, -1, -1, s);
      repeat (CPB) step();
      n_checks++; if (rise_data.size() != 1 || rise_data[0] !== b) begin n_fail++; $display("FAIL lowline_next_frame: got %0d bytes expected 1 byte %h", rise_data.size(), b); end
   endtask

   task automatic test_good_frame();
      logic [7:0] b;
      int s;
      rx_ready = 1'b1;
      for (int it = 0; it < 4; it++) begin
         b = (it == 0) ? CH_1 : 8'($urandom);
         clear_log();
         repeat ($urandom_range(0, CPB)) step();
         send_frame(b, 1'b1, -1, -1, -1, s);
         repeat (2 * CPB) step();
         n_checks++; if (rise_cyc.size() !== 1) begin n_fail++; $display("FAIL good_rises[%0d]: got %0d expected 1", it, rise_cyc.size()); end
         n_checks++; if (rise_cyc.size() == 0 || rise_cyc[0] !== s + LAT) begin n_fail++; $display("FAIL good_latency[%0d]: got %0d expected %0d", it, (rise_cyc.size() > 0) ? rise_cyc[0] - s : -1, LAT); end
         n_checks++; if (rise_data.size() == 0 || rise_data[0] !== b) begin n_fail++; $display("FAIL good_data[%0d]: got %h expected %h", it, (rise_data.size() > 0) ? rise_data[0] : 8'hxx, b); end
         n_checks++; if (valid_cycles !== 1) begin n_fail++; $display("FAIL good_valid_cycles[%0d]: got %0d expected 1", it, valid_cycles); end
         n_checks++; if (fe_cnt + bd_cnt + ov_cnt !== 0) begin n_fail++; $display("FAIL good_pulses[%0d]: got %0d expected 0", it, fe_cnt + bd_cnt + ov_cnt); end
         n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL good_busy_after[%0d]: got %b expected 0", it, rx_busy); end
      end
   endtask

   task automatic test_glitch();
      int s, len, k, fidx;
      logic [7:0] b;
      clear_log();
      rx_ready = 1'b1;
      len = $urandom_range(1, HB - 2);
      step();
      rx_in = 1'b0;
      s = cyc;
      repeat (len) step();
      rx_in = 1'b1;
      // false start leaves START after the mid-bit vote; busy drops at t0+HB+3
      for (int n = 0; n < 4 * CPB && cyc < s + 2 + HB + 2; n++) step();
      n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_held: got %b expected 1", rx_busy); end
      step();
      n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_drop: got %b expected 0", rx_busy); end
      repeat (2 * CPB) step();
      n_checks++; if (rise_cyc.size() + fe_cnt + bd_cnt + ov_cnt !== 0) begin n_fail++; $display("FAIL glitch_events: got %0d expected 0", rise_cyc.size() + fe_cnt + bd_cnt + ov_cnt); end
      for (int it = 0; it < 4; it++) begin
         if (it == 0) begin
            b = CH_0; fidx = 3 * CPB + HB;
         end else begin
            b = 8'($urandom);
            k = $urandom_range(0, 9);
            fidx = k * CPB + HB - 1 + $urandom_range(0, 2);
         end
         clear_log();
         send_frame(b, 1'b1, fidx, -1, -1, s);
         repeat (CPB) step();
         n_checks++; if (rise_data.size() != 1 || rise_data[0] !== b) begin n_fail++; $display("FAIL spike_data[%0d]: got %0d bytes expected 1 byte %h", it, rise_data.size(), b); end
         n_checks++; if (fe_cnt + bd_cnt !== 0) begin n_fail++; $display("FAIL spike_errors[%0d]: got %0d expected 0", it, fe_cnt + bd_cnt); end
      end
   endtask

   task automatic test_frame_err();
      int s;
      logic [7:0] b;
      rx_ready = 1'b1;
      for (int it = 0; it < 2; it++) begin
         b = (it == 0) ? CH_LF : 8'($urandom_range(1, 255));
         clear_log();
         send_frame(b, 1'b0, -1, -1, -1, s);
         repeat (2 * CPB) step();
         n_checks++; if (fe_cnt !== 1) begin n_fail++; $display("FAIL ferr_count[%0d]: got %0d expected 1", it, fe_cnt); end
         n_checks++; if (fe_cyc !== s + LAT) begin n_fail++; $display("FAIL ferr_time[%0d]: got %0d expected %0d", it, fe_cyc - s, LAT); end
         n_checks++; if (bd_cnt + ov_cnt + rise_cyc.size() !== 0) begin n_fail++; $display("FAIL ferr_other[%0d]: got %0d expected 0", it, bd_cnt + ov_cnt + rise_cyc.size()); end
      end
      clear_log();
      send_frame(CH_1, 1'b1, -1, -1, -1, s);
      repeat (CPB) step();
      n_checks++; if (rise_data.size() != 1 || rise_data[0] !== CH_1) begin n_fail++; $display("FAIL ferr_recover: got %0d bytes expected 1 byte 31", rise_data.size()); end
   endtask

   task automatic test_break();
      int s;
      logic [7:0] b;
      rx_ready = 1'b1;
      clear_log();
      step();
      rx_in = 1'b0;
      s = cyc;
      repeat (12 * CPB) step();
      n_checks++; if (rise_cyc.size() !== 0) begin n_fail++; $display("FAIL break_valid_low: got %0d expected 0", rise_cyc.size()); end
      rx_in = 1'b1;
      repeat (2 * CPB) step();
      n_checks++; if (bd_cnt !== 1) begin n_fail++; $display("FAIL break_count: got %0d expected 1", bd_cnt); end
      n_checks++; if (bd_cyc !== s + LAT) begin n_fail++; $display("FAIL break_time: got %0d expected %0d", bd_cyc - s, LAT); end
      n_checks++; if (fe_cnt + ov_cnt + rise_cyc.size() !== 0) begin n_fail++; $display("FAIL break_other: got %0d expected 0", fe_cnt + ov_cnt + rise_cyc.size()); end
      b = 8'($urandom);
      clear_log();
      send_frame(b, 1'b1, -1, -1, -1, s);
      repeat (CPB) step();
      n_checks++; if (rise_data.size() != 1 || rise_data[0] !== b) begin n_fail++; $display("FAIL break_recover: got %0d bytes expected 1 byte %h", rise_data.size(), b); end
   endtask

   task automatic test_overrun();
      int s1, s2;
      rx_ready = 1'b0;
      clear_log();
      send_frame(CH_0, 1'b1, -1, -1, -1, s1);
      send_frame(CH_1, 1'b1, -1, -1, -1, s2);
      repeat (CPB) step();
      n_checks++; if (ov_cnt !== 1) begin n_fail++; $display("FAIL ovr_count: got %0d expected 1", ov_cnt); end
      n_checks++; if (ov_cyc !== s2 + LAT) begin n_fail++; $display("FAIL ovr_time: got %0d expected %0d", ov_cyc - s2, LAT); end
      n_checks++; if (rx_data !== CH_0) begin n_fail++; $display("FAIL ovr_data_kept: got %h expected 30", rx_data); end
      n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_held: got %b expected 1", rx_valid); end
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept_clear: got %b expected 0", rx_valid); end
      n_checks++; if (acc_data.size() != 1 || acc_data[0] !== CH_0) begin n_fail++; $display("FAIL ovr_accepted: got %0d bytes expected 1 byte 30", acc_data.size()); end
      // accept the held byte in exactly the cycle the next byte completes
      clear_log();
      send_frame(CH_0, 1'b1, -1, -1, -1, s1);
      send_frame(CH_1, 1'b1, -1, LAT - 1, -1, s2);
      repeat (CPB) step();
      n_checks++; if (ov_cnt !== 0) begin n_fail++; $display("FAIL swap_overrun: got %0d expected 0", ov_cnt); end
      n_checks++; if (rx_data !== CH_1) begin n_fail++; $display("FAIL swap_data: got %h expected 31", rx_data); end
      n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL swap_valid: got %b expected 1", rx_valid); end
      rx_ready = 1'b1;
      repeat (2) step();
   endtask

   task automatic test_loopback();
      logic [31:0] val, got;
      logic [7:0]  chars[33];
      int r, j, i, s, bad;
      bit done_rst;
      val = $urandom;
      for (int k = 0; k < 32; k++) chars[k] = val[31 - k] ? CH_1 : CH_0;
      chars[32] = CH_LF;
      r = $urandom_range(3, 30);
      j = $urandom_range(CPB + 1, 8 * CPB);
      rx_ready = 1'b1;
      clear_log();
      i = 0;
      done_rst = 0;
      while (i < 33) begin
         if (!done_rst && i == r - 1) rx_ready = 1'b0;
         if (!done_rst && i == r) begin
            n_checks++; if (rx_valid !== 1'b1 || rx_data !== chars[r - 1]) begin n_fail++; $display("FAIL loop_held: got %b/%h expected 1/%h", rx_valid, rx_data, chars[r - 1]); end
            send_frame(chars[i], 1'b1, -1, -1, j, s);
            n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL loop_rst_valid: got %b expected 0", rx_valid); end
            n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL loop_rst_busy: got %b expected 0", rx_busy); end
            rx_ready = 1'b1;
            repeat (CPB + 2) step();
            done_rst = 1;
            i = r - 1;
         end else begin
            send_frame(chars[i], 1'b1, -1, -1, -1, s);
            i++;
         end
      end
      repeat (2 * CPB) step();
      n_checks++; if (acc_data.size() !== 33) begin n_fail++; $display("FAIL loop_count: got %0d expected 33", acc_data.size()); end
      bad = 0;
      got = '0;
      for (int k = 0; k < 33 && k < acc_data.size(); k++) begin
         if (acc_data[k] !== chars[k]) bad++;
         if (k < 32) got = {got[30:0], acc_data[k] == CH_1};
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL loop_chars: got %0d wrong expected 0", bad); end
      n_checks++; if (got !== val) begin n_fail++; $display("FAIL loop_value: got %h expected %h", got, val); end
      n_checks++; if (fe_cnt + bd_cnt + ov_cnt !== 0) begin n_fail++; $display("FAIL loop_pulses: got %0d expected 0", fe_cnt + bd_cnt + ov_cnt); end
   endtask

   initial begin
      clear_log();
      test_reset();
      test_reset_low_line();
      test_good_frame();
      test_glitch();
      test_frame_err();
      test_break();
      test_overrun();
      test_loopback();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
